// File: rtl/nibble_in_port.sv
// nibble_in_port: synchronises an asynchronous input bus into clk, detects
// value changes once the synchroniser has settled, and queues each new
// value in a show-ahead FIFO. The FIFO is drained through a valid/enable
// read interface.
module nibble_in_port #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           level,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sv;
    logic [KW-1:0]    prime_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             prime_last, change, full, do_pop, do_push, drop;

    assign sv       = sync_q[SYNC_STAGES-1];
    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Synchroniser chain: shifts data_in through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage sample the previous
        // stage's old value, so the chain really shifts by one per edge.
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= PRIME;
        else     state <= next_state;
    end

    // Next-state and per-edge control: priming end, change detect, push/pop.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        prime_last = 1'b0;
        change     = 1'b0;
        case (state)
            PRIME: begin
                if (prime_cnt == KW'(SYNC_STAGES)) begin
                    prime_last = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: change = (sv != level);
            default: next_state = PRIME;
        endcase
        do_pop  = rd_en && rd_valid;
        do_push = change && (!full || do_pop);
        drop    = change && full && !do_pop;
    end

    // Priming counter: counts edges until the synchroniser holds real data.
    always_ff @(posedge clk) begin
        if (rst)                              prime_cnt <= '0;
        else if (state == PRIME && !prime_last) prime_cnt <= prime_cnt + KW'(1);
    end

    // Baseline value: captured at the end of PRIME, then tracks each change
    // (also when the change is dropped, so it is not re-detected).
    always_ff @(posedge clk) begin
        if (rst)                      level <= '0;
        else if (prime_last || change) level <= sv;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only visible
        // through rd_data while rd_valid=1, and the pointers are reset.
        if (do_push) mem[wr_ptr] <= sv;
    end

    // Sticky overflow flag; a drop on the same edge beats a clear.
    always_ff @(posedge clk) begin
        if (rst)               overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_nibble_in_port.sv
// Bench for nibble_in_port: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_nibble_in_port;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] level;
    logic [2:0]       count;
    logic             overflow;
    logic             clr_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_in_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .level        (level),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: input history delays data_in by SYNC edges, a plain
    // queue holds the FIFO contents, and edges since reset release decide
    // when change detection begins.
    logic [WIDTH-1:0] m_hist [SYNC];
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_level = '0;
    logic             m_ovf   = 1'b0;
    int               m_prime = 0;

    always @(posedge clk) begin
        logic [WIDTH-1:0] sv;
        bit               pop;
        bit               ev;
        sv = m_hist[SYNC-1];
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_level = '0;
            m_prime = 0;
        end else begin
            pop = rd_en && (m_q.size() > 0);
            ev  = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (m_prime < SYNC) begin
                m_prime++;
            end else if (m_prime == SYNC) begin
                m_level = sv;
                m_prime++;
            end else if (sv != m_level) begin
                m_level = sv;
                if (m_q.size() < DEPTH) m_q.push_back(sv);
                else                    ev = 1'b1;
            end
            if (ev)                m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = data_in;
        end
    end

    // Cycle-by-cycle comparison against the model, 1 time unit after the edge.
    always begin
        @(posedge clk);
        #1;
        check("m_rd_valid", rd_valid, m_q.size() != 0);
        check("m_count", count, m_q.size());
        if (m_q.size() != 0) check("m_rd_data", rd_data, m_q[0]);
        check("m_level", level, m_level);
        check("m_overflow", overflow, m_ovf);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_expect(input string name, input logic [WIDTH-1:0] v);
        check({name, "_valid"}, rd_valid, 1'b1);
        check({name, "_data"}, rd_data, v);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        data_in      = 4'hA;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;

        // Reset state and priming with 4'hA held across release.
        cycles(1);
        check("rst_count", count, 0);
        check("rst_level", level, 0);
        check("rst_valid", rd_valid, 0);
        cycles(1);
        rst = 1'b0;
        cycles(3);
        check("prime_level", level, 4'hA);
        check("prime_valid", rd_valid, 0);
        check("prime_count", count, 0);

        // Latency: 4'h3 set before E0 appears right after E0+2.
        data_in = 4'h3;
        cycles(1);
        check("lat_e0", rd_valid, 0);
        cycles(1);
        check("lat_e1", rd_valid, 0);
        cycles(1);
        check("lat_valid", rd_valid, 1);
        check("lat_data", rd_data, 4'h3);
        check("lat_count", count, 1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("lat_pop_valid", rd_valid, 0);
        check("lat_pop_count", count, 0);

        // rd_en while empty does nothing.
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("empty_rd_count", count, 0);

        // Fill to full, then one more change overflows.
        for (int v = 1; v <= 5; v++) begin
            data_in = 4'(v);
            cycles(1);
        end
        cycles(2);
        check("fill_count", count, 4);
        check("fill_ovf", overflow, 1);
        check("fill_level", level, 4'h5);
        for (int v = 1; v <= 4; v++) pop_expect("drain1", 4'(v));
        check("drain1_empty", rd_valid, 0);
        check("drain1_level", level, 4'h5);

        // Clear overflow on an idle cycle.
        clr_overflow = 1'b1;
        cycles(1);
        clr_overflow = 1'b0;
        check("clr_idle", overflow, 0);

        // Full FIFO: push 4'h6 and pop on the same edge.
        for (int v = 1; v <= 4; v++) begin
            data_in = 4'(v);
            cycles(1);
        end
        data_in = 4'h6;
        cycles(2);
        check("full_count", count, 4);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("pp_count", count, 4);
        check("pp_ovf", overflow, 0);
        check("pp_head", rd_data, 4'h2);

        // Clear on the same edge as an overflow: set wins.
        data_in = 4'h7;
        cycles(2);
        clr_overflow = 1'b1;
        cycles(1);
        clr_overflow = 1'b0;
        check("set_wins_ovf", overflow, 1);
        check("set_wins_count", count, 4);
        clr_overflow = 1'b1;
        cycles(1);
        clr_overflow = 1'b0;
        check("clr_later", overflow, 0);
        pop_expect("drain2", 4'h2);
        pop_expect("drain2", 4'h3);
        pop_expect("drain2", 4'h4);
        pop_expect("drain2", 4'h6);
        check("drain2_empty", rd_valid, 0);
        check("drain2_level", level, 4'h7);

        // Mid-operation reset discards queued data and overflow.
        for (int v = 8; v <= 12; v++) begin
            data_in = 4'(v);
            cycles(1);
        end
        cycles(2);
        check("pre_rst_count", count, 4);
        check("pre_rst_ovf", overflow, 1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        cycles(3);
        check("reprime_level", level, 4'hC);
        check("reprime_count", count, 0);
        cycles(2);
        check("no_stale", rd_valid, 0);

        // Push into empty FIFO with rd_en held: no pop on the push edge.
        rd_en   = 1'b1;
        data_in = 4'hD;
        cycles(3);
        check("pe_valid", rd_valid, 1);
        check("pe_data", rd_data, 4'hD);
        cycles(1);
        rd_en = 1'b0;
        check("pe_popped", rd_valid, 0);

        // Wrap-around: ten push/pop pairs, occupancy never above one.
        for (int v = 0; v < 10; v++) begin
            data_in = 4'(v);
            for (int k = 0; k < 6 && !rd_valid; k++) cycles(1);
            check("wrap_count", count, 1);
            pop_expect("wrap", 4'(v));
        end
        check("wrap_empty", rd_valid, 0);
        check("wrap_level", level, 4'h9);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
